// File: rtl/csr_counter_array.sv
`default_nettype none
// ============================================================================
//  Module   : csr_counter_array
//  Purpose  : Machine-mode counter CSRs. Covers mcycle, minstret and the
//             NUM_HPM event counters, their user read-only shadows,
//             mcountinhibit and the mhpmevent selectors.
//  Revision : 1.0  initial release
// ============================================================================
module csr_counter_array #(
   parameter int NUM_HPM   = 4,
   parameter int CNT_WIDTH = 64,
   parameter int NUM_EVT   = 8,
   parameter int EVT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_csr_ex,
   input  logic [11:0]          csr_ofs_ex,
   input  logic [4:0]           csr_uimm_ex,
   input  logic [2:0]           csr_op2_ex,
   input  logic [31:0]          rs1_sel,
   input  logic                 stall,
   input  logic                 retire_ex,
   input  logic [NUM_EVT-1:0]   hpm_events,
   output logic                 csr_cnt_hit,
   output logic [31:0]          csr_cnt_rd_data,
   output logic [NUM_HPM+2:0]   cnt_ovf
);

   localparam int              NIDX     = NUM_HPM + 3;
   localparam logic [4:0]      MAX_IDX  = 5'(NUM_HPM + 2);
   // Bit 1 of mcountinhibit has no counter behind it and is hardwired to 0.
   localparam logic [NIDX-1:0] INH_MASK = ~NIDX'(2);

   logic [4:0]      sel_idx;
   logic            is_hi;
   logic            is_shadow;
   logic            is_cnt;
   logic            is_inh;
   logic            is_evt;
   logic            idx_valid;
   logic            wr_en;
   logic [31:0]     wdata;
   logic [31:0]     new_val;
   logic [NIDX-1:0] inhibit;
   logic [63:0]     cnt_ext [NIDX];
   logic [31:0]     evt_rd  [NIDX];

   // ---------------------------------------------------------------- decode
   assign sel_idx   = csr_ofs_ex[4:0];
   assign is_hi     = csr_ofs_ex[7];
   assign is_shadow = (csr_ofs_ex[11:8] == 4'hC);
   assign idx_valid = (sel_idx != 5'd1) && (sel_idx <= MAX_IDX);
   assign is_cnt    = ((csr_ofs_ex[11:8] == 4'hB) || is_shadow) &&
                      (csr_ofs_ex[6:5] == 2'b00) && idx_valid;
   assign is_inh    = (csr_ofs_ex == 12'h320);
   assign is_evt    = (csr_ofs_ex[11:5] == 7'h19) &&
                      (sel_idx >= 5'd3) && (sel_idx <= MAX_IDX);
   assign csr_cnt_hit = is_cnt | is_inh | is_evt;

   // Shadows (Cxx) are readable but writes to them are silently dropped.
   assign wr_en = ~stall & cmd_csr_ex & csr_cnt_hit &
                  (csr_op2_ex[1:0] != 2'b00) & ~is_shadow;
   assign wdata = csr_op2_ex[2] ? {27'b0, csr_uimm_ex} : rs1_sel;

   // Read mux: the current (pre-update) value of the addressed CSR
   always_comb begin
      csr_cnt_rd_data = '0;
      for (int i = 0; i < NIDX; i++) begin
         if (sel_idx == 5'(i)) begin
            if (is_cnt)
               csr_cnt_rd_data = is_hi ? cnt_ext[i][63:32] : cnt_ext[i][31:0];
            else if (is_evt)
               csr_cnt_rd_data = evt_rd[i];
         end
      end
      if (is_inh)
         csr_cnt_rd_data = 32'(inhibit);
   end

   // Read-modify-write value; the old value is the current read data
   always_comb begin
      case (csr_op2_ex[1:0])
         2'b10:   new_val = csr_cnt_rd_data | wdata;
         2'b11:   new_val = csr_cnt_rd_data & ~wdata;
         default: new_val = wdata;
      endcase
   end

   // mcountinhibit register; new value applies from the next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         inhibit <= '0;
      else if (wr_en && is_inh)
         inhibit <= new_val[NIDX-1:0] & INH_MASK;
   end

   // ------------------------------------------------------- counter slots
   for (genvar i = 0; i < NIDX; i++) begin : g_idx
      if (i == 1) begin : g_hole
         assign cnt_ext[i] = '0;
         assign evt_rd[i]  = '0;
         assign cnt_ovf[i] = 1'b0;
      end else begin : g_cnt
         logic [CNT_WIDTH-1:0] cnt;
         logic                 ovf;
         logic                 fire;
         logic                 wr_lo;
         logic                 wr_hi;

         assign wr_lo = wr_en & is_cnt & ~is_hi & (sel_idx == 5'(i));
         assign wr_hi = wr_en & is_cnt &  is_hi & (sel_idx == 5'(i));

         if (i == 0) begin : g_cycle
            assign fire      = ~inhibit[0];
            assign evt_rd[i] = '0;
         end else if (i == 2) begin : g_instret
            assign fire      = retire_ex & ~stall & ~inhibit[2];
            assign evt_rd[i] = '0;
         end else begin : g_hpm
            logic [EVT_WIDTH-1:0] evt;
            logic                 evt_hit;

            // Event selector register; only the implemented bits are kept
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  evt <= '0;
               else if (wr_en && is_evt && (sel_idx == 5'(i)))
                  evt <= new_val[EVT_WIDTH-1:0];
            end

            // Selector e counts hpm_events[e-1]; 0 and out-of-range never fire
            always_comb begin
               evt_hit = 1'b0;
               for (int e = 1; e <= NUM_EVT; e++) begin
                  if ((evt == EVT_WIDTH'(e)) && hpm_events[e-1])
                     evt_hit = 1'b1;
               end
            end

            assign fire      = evt_hit & ~inhibit[i];
            assign evt_rd[i] = 32'(evt);
         end

         // Counter: a write to either half wins over the increment
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt <= '0;
               ovf <= 1'b0;
            end else begin
               ovf <= 1'b0;
               if (wr_lo)
                  cnt[31:0] <= new_val;
               if (wr_hi)
                  cnt[CNT_WIDTH-1:32] <= new_val[CNT_WIDTH-33:0];
               if (!wr_lo && !wr_hi && fire) begin
                  cnt <= cnt + CNT_WIDTH'(1);
                  ovf <= &cnt;
               end
            end
         end

         assign cnt_ext[i] = 64'(cnt);
         assign cnt_ovf[i] = ovf;
      end
   end

endmodule
`default_nettype wire
